// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, the AXI OKAY response code and the fault instruction word.
// Imported by ysyx_25030093_ifu.
package ysyx_25030093_ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [31:0] IFU_FAULT_INST = 32'h0000_0000;

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: takes one PC, issues a single-beat read, hands the word to decode.
// Latency: 3 cycles accept->inst_valid on a zero-wait bus (1 cycle for a misaligned PC).
// Backpressure: pc_ready only in IDLE; arready/rvalid/inst_ready stalls hold the current state.
// Ports: clk/rst (sync, active-low); pc/pc_valid/pc_ready from the PC stage; flush redirect;
//        araddr/arvalid/arready and rdata/rresp/rvalid/rready to the bus;
//        inst/inst_pc/inst_fault/inst_valid/inst_ready to decode.
module ysyx_25030093_ifu
    import ysyx_25030093_ifu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    output logic            inst_valid,
    input  logic            inst_ready
);

    ifu_state_e      state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] araddr_q, araddr_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_fault_q, inst_fault_d;
    logic            inst_valid_q, inst_valid_d;

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        pc_d         = pc_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        inst_valid_d = inst_valid_q;

        case (state_q)
            S_IDLE: begin
                // A PC presented together with flush is already the redirect target.
                if (pc_valid) begin
                    pc_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned: report straight away, never touch the bus.
                        inst_d       = IFU_FAULT_INST;
                        inst_pc_d    = pc;
                        inst_fault_d = 1'b1;
                        inst_valid_d = 1'b1;
                        state_d      = S_OUT;
                    end else begin
                        araddr_d  = pc;
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end
            end
            S_AR: begin
                // arvalid is never withdrawn; a flush only marks the fetch for discard.
                if (flush) kill_d = 1'b1;
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        inst_d       = (rresp == RESP_OKAY) ? rdata : IFU_FAULT_INST;
                        inst_fault_d = (rresp != RESP_OKAY);
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_OUT;
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            S_OUT: begin
                // Flush and handshake both leave for IDLE; a coincident handshake still counts.
                if (inst_ready || flush) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            kill_q       <= 1'b0;
            pc_q         <= '0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            pc_q         <= pc_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // pc_ready is the only combinational output; it is held low during reset.
    assign pc_ready   = (state_q == S_IDLE) && rst;
    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
module tb_ysyx_25030093_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_valid;
    logic        inst_ready;

    int tests_run    = 0;
    int tests_failed = 0;
    int ar_beats     = 0;

    ysyx_25030093_ifu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst && arvalid && arready) ar_beats <= ar_beats + 1;

    // One complete fetch. The expected instruction/fault come from the fetch rules:
    // misaligned -> fault, no bus; non-OKAY -> fault with a zero word; otherwise rdata.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input int arw, input int rw, input int ow, input logic fl0);
        logic        mis, ef;
        logic [31:0] ei;
        int          b0;
        mis = (a[1:0] != 2'b00);
        ef  = mis || (resp != 2'b00);
        ei  = ef ? 32'h0 : d;
        b0  = ar_beats;
        tests_run++;
        if (pc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL fetch_pc_ready_idle pc=%h actual=%b required=1", a, pc_ready);
        end
        pc = a; pc_valid = 1'b1; flush = fl0;
        @(negedge clk);
        pc_valid = 1'b0; flush = 1'b0; pc = $urandom;
        if (!mis) begin
            for (int i = 0; i <= arw; i++) begin
                tests_run++;
                if (arvalid !== 1'b1 || araddr !== a || pc_ready !== 1'b0 || inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fetch_ar pc=%h cyc=%0d actual arvalid=%b araddr=%h pc_ready=%b required 1/%h/0",
                             a, i, arvalid, araddr, pc_ready, a);
                end
                arready = (i == arw);
                @(negedge clk);
            end
            arready = 1'b0;
            for (int i = 0; i <= rw; i++) begin
                tests_run++;
                if (rready !== 1'b1 || arvalid !== 1'b0 || inst_valid !== 1'b0 || pc_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fetch_r pc=%h cyc=%0d actual rready=%b arvalid=%b inst_valid=%b required 1/0/0",
                             a, i, rready, arvalid, inst_valid);
                end
                rvalid = (i == rw);
                rdata  = (i == rw) ? d : $urandom;
                rresp  = (i == rw) ? resp : 2'($urandom);
                @(negedge clk);
            end
            rvalid = 1'b0;
        end else begin
            tests_run++;
            if (arvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL misaligned_no_ar pc=%h actual arvalid=%b required 0", a, arvalid);
            end
        end
        for (int i = 0; i <= ow; i++) begin
            tests_run++;
            if (inst_valid !== 1'b1 || inst !== ei || inst_pc !== a || inst_fault !== ef || pc_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL fetch_out pc=%h cyc=%0d actual v=%b inst=%h ipc=%h f=%b required 1/%h/%h/%b",
                         a, i, inst_valid, inst, inst_pc, inst_fault, ei, a, ef);
            end
            inst_ready = (i == ow);
            @(negedge clk);
        end
        inst_ready = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || pc_ready !== 1'b1 || (ar_beats - b0) !== (mis ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL fetch_done pc=%h actual v=%b pc_ready=%b ar_beats=%0d required 0/1/%0d",
                     a, inst_valid, pc_ready, ar_beats - b0, mis ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; pc = '0; pc_valid = 0; flush = 0; arready = 0; rdata = '0;
        rresp = '0; rvalid = 0; inst_ready = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (pc_ready !== 0 || arvalid !== 0 || rready !== 0 || inst_valid !== 0 || inst !== 0 ||
            inst_pc !== 0 || inst_fault !== 0 || araddr !== 0) begin
            tests_failed++;
            $display("FAIL reset_state actual pr=%b av=%b rr=%b iv=%b inst=%h ipc=%h f=%b ad=%h required all 0",
                     pc_ready, arvalid, rready, inst_valid, inst, inst_pc, inst_fault, araddr);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (pc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_pc_ready actual=%b required 1", pc_ready);
        end
    endtask

    task automatic test_directed();
        do_fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 1'b0);  // zero-wait
        do_fetch(32'h8000_0004, 32'h0010_0093, 2'b00, 3, 2, 2, 1'b0);  // backpressure
        do_fetch(32'h8000_0002, 32'h0,         2'b00, 0, 0, 0, 1'b0);  // misaligned
        do_fetch(32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 0, 1, 0, 1'b0);  // bus error
        do_fetch(32'h8000_000C, 32'hCAFE_0013, 2'b00, 1, 0, 1, 1'b1);  // flush with accept
    endtask

    task automatic test_stray_rvalid();
        rvalid = 1'b1; rdata = 32'h1111_2222;
        @(negedge clk);
        rvalid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || pc_ready !== 1'b1 || rready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_rvalid_idle actual iv=%b pr=%b rr=%b required 0/1/0", inst_valid, pc_ready, rready);
        end
    endtask

    task automatic test_flush_r();
        pc = 32'h8000_0080; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (inst_valid !== 1'b0 || rready !== 1'b1) begin
                tests_failed++;
                $display("FAIL flush_r_wait cyc=%0d actual iv=%b rr=%b required 0/1", i, inst_valid, rready);
            end
            flush  = (i == 1);
            rvalid = (i == 4);
            rdata  = 32'h1234_5678;
            rresp  = 2'b00;
            @(negedge clk);
        end
        flush = 1'b0; rvalid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_r_discard actual iv=%b pr=%b required 0/1", inst_valid, pc_ready);
        end
        do_fetch(32'h8000_0100, 32'h00A0_0513, 2'b00, 0, 0, 0, 1'b0);
    endtask

    task automatic test_flush_ar();
        pc = 32'h8000_0200; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests_run++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0200) begin
            tests_failed++;
            $display("FAIL flush_ar_hold actual av=%b ad=%h required 1/80000200", arvalid, araddr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h5555_AAAA; rresp = 2'b00;
        @(negedge clk);
        rvalid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_ar_discard actual iv=%b pr=%b required 0/1", inst_valid, pc_ready);
        end
    endtask

    task automatic test_flush_out();
        pc = 32'h8000_0301; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b1 || inst_fault !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_out_pre actual iv=%b f=%b required 1/1", inst_valid, inst_fault);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_out actual iv=%b pr=%b required 0/1", inst_valid, pc_ready);
        end
    endtask

    task automatic test_reset_mid_ar();
        pc = 32'h8000_0040; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        tests_run++;
        if (arvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_ar_pre actual av=%b required 1", arvalid);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (arvalid !== 1'b0 || inst_valid !== 1'b0 || pc_ready !== 1'b0 || rready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_ar actual av=%b iv=%b pr=%b rr=%b required 0/0/0/0", arvalid, inst_valid, pc_ready, rready);
        end
        rst = 1'b1;
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'h7777_0000;
        @(negedge clk);
        rvalid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || pc_ready !== 1'b1 || arvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_ar_stray actual iv=%b pr=%b av=%b required 0/1/0", inst_valid, pc_ready, arvalid);
        end
        do_fetch(32'h8000_0044, 32'h0000_0297, 2'b00, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, d;
            logic [1:0]  resp;
            a    = 32'h8000_0000 | ($urandom & 32'h000F_FFFF);
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            d    = $urandom;
            resp = ($urandom_range(4) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            do_fetch(a, d, resp, $urandom_range(3), $urandom_range(3), $urandom_range(3),
                     1'($urandom_range(1)));
            if ($urandom_range(3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stray_rvalid();
        test_flush_r();
        test_flush_ar();
        test_flush_out();
        test_reset_mid_ar();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ysyx_25030093_ifu.md
# ysyx_25030093_ifu

Instruction fetch unit sitting directly downstream of the PC register: it accepts each new PC over a valid/ready handshake and issues a single-beat AXI4-Lite-style read for the instruction word. It returns the word, its PC and a fault flag to decode over a second valid/ready handshake. It supports one outstanding fetch, flush on redirect with in-flight discard, and misaligned-PC / bus-error fault reporting.

## Interface
- `XLEN`, 32, address and data width (only 32 supported)
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-low
- `pc`  in  XLEN  fetch address from PC stage
- `pc_valid`  in  1  `pc` holds a new fetch address
- `pc_ready`  out  1  IFU can accept a PC this cycle
- `flush`  in  1  redirect: kill any fetch accepted in an earlier cycle
- `araddr`  out  XLEN  read address
- `arvalid` / `arready`  out / in  1  read-address handshake
- `rdata`  in  XLEN  read data
- `rresp`  in  2  read response, 2'b00 = OKAY
- `rvalid` / `rready`  in / out  1  read-data handshake
- `inst`  out  32  fetched instruction (0 on fault)
- `inst_pc`  out  XLEN  PC of `inst`
- `inst_fault`  out  1  misaligned PC or non-OKAY response
- `inst_valid` / `inst_ready`  out / in  1  decode handshake

## Operation
- States: IDLE, AR, R, OUT; plus `kill` flag.
- IDLE: `pc_ready`=1. On `pc_valid`: latch `pc`; if `pc[1:0]`≠0 → OUT with `inst`=0, `inst_fault`=1, no bus access; else `araddr`=`pc` → AR.
- AR: `arvalid`=1, `araddr` stable until `arready`; then → R.
- R: `rready`=1. On `rvalid`: if `kill` → drop data, clear `kill`, → IDLE; else `inst`=`rdata` (0 if `rresp`≠OKAY), `inst_fault`=(`rresp`≠OKAY), `inst_pc`=latched PC → OUT.
- OUT: `inst_valid`=1, outputs stable; on `inst_ready` → IDLE.
- Flush: in IDLE no effect (a PC accepted in the flush cycle is the new target and proceeds). In AR or R: set `kill`; AR still completes its address handshake (never drop `arvalid`). In OUT: → IDLE, `inst_valid` deasserts next cycle; flush with `inst_ready` in same cycle: handshake counts, next state IDLE.
- One fetch outstanding at most; `rvalid` outside R ignored.
- Reset (`rst`=0 at edge, any state): state IDLE, `kill`=0, `arvalid`=0, `rready`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_fault`=0, `araddr`=0. `pc_ready` forced 0 while `rst`=0. Mid-transaction reset abandons the fetch; a late `rvalid` after reset is ignored (state IDLE).

## Timing
- All outputs registered except `pc_ready`=(state==IDLE)&`rst`.
- Zero-wait bus: accept at cycle 0, `arvalid` cycle 1 (`arready` same cycle), `rvalid` cycle 2, `inst_valid` cycle 3, next `pc_ready` cycle 4 → min 4 cycles per fetch.
- Misaligned: accept cycle 0, `inst_valid` cycle 1.
- Wait states on `arready`/`rvalid`/`inst_ready` extend the respective state 1:1; no timeout.

## Structure
- Package `ysyx_25030093_ifu_pkg`: state enum (IDLE/AR/R/OUT), `RESP_OKAY`=2'b00, `IFU_FAULT_INST`=32'h0.
- Single module, no sub-module; one state register, one datapath register set.

## Test plan
- Zero-wait fetch: pc=0x8000_0000, rdata=0x0000_0413 → `araddr`=0x8000_0000 cycle 1, `inst`=0x0000_0413, `inst_pc`=0x8000_0000, `inst_valid` cycle 3, fault 0.
- Backpressure: `arready` low 3 cycles, `rvalid` 2 cycles late, `inst_ready` low 2 cycles → `araddr`/`inst` stable throughout, `pc_ready` low until handshake done, exactly one AR beat.
- Misaligned: pc=0x8000_0002 → no `arvalid`, `inst_valid`=1 cycle 1, `inst`=0, `inst_fault`=1.
- Bus error: `rresp`=2'b10, rdata=0xDEAD_BEEF → `inst`=0, `inst_fault`=1, `inst_pc` = requested PC.
- Flush in R: flush while waiting, `rvalid` 2 cycles later with 0x1234_5678 → no `inst_valid`, IDLE after `rvalid`, next fetch pc=0x8000_0100 returns its own data.
- Reset mid-AR: `rst`=0 while `arvalid`=1 → next cycle `arvalid`=0, `inst_valid`=0, state IDLE; stray `rvalid` after release ignored.
